// File: rtl/async_counter_if.sv
// Bus bundle for async_counter: count enable in, count value and cascade flags out.
// The master side drives the enable; the slave side is the counter itself.
interface async_counter_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output en,
    input  count,
    input  tc,
    input  wrap
  );

  modport slave (
    input  en,
    output count,
    output tc,
    output wrap
  );

endinterface

// File: rtl/async_counter.sv
// Synchronous up-counter built from per-bit toggle stages, with terminal-count and wrap flags.
// Optional build macro ASYNC_COUNTER_SAT_EN: saturate at all ones instead of wrapping.
module async_counter #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  async_counter_if.slave  bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH:0]   carry_s;

  // Toggle-chain next state: bit i flips when enabled and all lower bits are set.
  always_comb begin
    carry_s    = {(WIDTH + 1){1'b0}};
    count_d    = count_q;
    wrap_d     = 1'b0;
    carry_s[0] = bus.en;
    for (int i = 0; i < WIDTH; i++) begin
      carry_s[i + 1] = carry_s[i] & count_q[i];
      count_d[i]     = count_q[i] ^ carry_s[i];
    end
`ifdef ASYNC_COUNTER_SAT_EN
    // Carry out of the top bit means we are at all ones: hold there, never flag a wrap.
    if (carry_s[WIDTH]) begin
      count_d = count_q;
    end else begin
      count_d = count_d;
    end
    wrap_d = 1'b0;
`else
    wrap_d = carry_s[WIDTH];
`endif
  end

  // State registers; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {WIDTH{1'b0}};
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = &count_q;

endmodule

// File: tb/tb_async_counter.sv
// Directed self-checking bench for async_counter at WIDTH=4, covering both build variants.
module tb_async_counter;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  async_counter_if #(.WIDTH(WIDTH)) bus ();

  async_counter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    bus.en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    bus.en = 1'b0;
    step();
    step();
    checks++;
    if (bus.count !== 4'b0000) begin
      errors++;
      $display("FAIL reset_count: got %b expected 0000", bus.count);
    end
    checks++;
    if (bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_tc: got %b expected 0", bus.tc);
    end
    checks++;
    if (bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrap: got %b expected 0", bus.wrap);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.count !== 4'b0000) begin
      errors++;
      $display("FAIL release_idle: got %b expected 0000", bus.count);
    end
  endtask

  task automatic test_count();
    logic [3:0] exp_v;
    bus.en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp_v = 4'(i);
      checks++;
      if (bus.count !== exp_v) begin
        errors++;
        $display("FAIL count_step%0d: got %b expected %b", i, bus.count, exp_v);
      end
    end
    bus.en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.count !== 4'b1010) begin
        errors++;
        $display("FAIL count_hold%0d: got %b expected 1010", i, bus.count);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_v;
    do_reset();
    bus.en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      exp_v = 4'(i);
      checks++;
      if (bus.count !== exp_v || bus.tc !== (i == 15) || bus.wrap !== 1'b0) begin
        errors++;
        $display("FAIL wrap_ramp%0d: got count=%b tc=%b wrap=%b expected count=%b tc=%0d wrap=0",
                 i, bus.count, bus.tc, bus.wrap, exp_v, (i == 15));
      end
    end
    step();
`ifdef ASYNC_COUNTER_SAT_EN
    checks++;
    if (bus.count !== 4'b1111 || bus.tc !== 1'b1 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL sat_edge16: got count=%b tc=%b wrap=%b expected count=1111 tc=1 wrap=0",
               bus.count, bus.tc, bus.wrap);
    end
`else
    checks++;
    if (bus.count !== 4'b0000 || bus.tc !== 1'b0 || bus.wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_edge: got count=%b tc=%b wrap=%b expected count=0000 tc=0 wrap=1",
               bus.count, bus.tc, bus.wrap);
    end
    step();
    checks++;
    if (bus.count !== 4'b0001 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_after: got count=%b wrap=%b expected count=0001 wrap=0",
               bus.count, bus.wrap);
    end
`endif
    bus.en = 1'b0;
  endtask

  task automatic test_reset_priority();
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (bus.count !== 4'b0101) begin
      errors++;
      $display("FAIL prio_setup: got %b expected 0101", bus.count);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.count !== 4'b0000) begin
      errors++;
      $display("FAIL prio_reset: got %b expected 0000", bus.count);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.count !== 4'b0001) begin
      errors++;
      $display("FAIL prio_resume: got %b expected 0001", bus.count);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_hold_at_max();
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 15; i++) step();
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.count !== 4'b1111 || bus.tc !== 1'b1 || bus.wrap !== 1'b0) begin
        errors++;
        $display("FAIL max_hold%0d: got count=%b tc=%b wrap=%b expected count=1111 tc=1 wrap=0",
                 i, bus.count, bus.tc, bus.wrap);
      end
    end
`ifndef ASYNC_COUNTER_SAT_EN
    bus.en = 1'b1;
    step();
    checks++;
    if (bus.count !== 4'b0000 || bus.wrap !== 1'b1) begin
      errors++;
      $display("FAIL max_rewrap: got count=%b wrap=%b expected count=0000 wrap=1",
               bus.count, bus.wrap);
    end
    bus.en = 1'b0;
    step();
    checks++;
    if (bus.count !== 4'b0000 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL max_idle_after: got count=%b wrap=%b expected count=0000 wrap=0",
               bus.count, bus.wrap);
    end
`endif
  endtask

`ifdef ASYNC_COUNTER_SAT_EN
  task automatic test_saturate();
    logic [3:0] exp_v;
    do_reset();
    bus.en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp_v = (i >= 15) ? 4'b1111 : 4'(i);
      checks++;
      if (bus.count !== exp_v || bus.wrap !== 1'b0) begin
        errors++;
        $display("FAIL sat_step%0d: got count=%b wrap=%b expected count=%b wrap=0",
                 i, bus.count, bus.wrap, exp_v);
      end
    end
    bus.en = 1'b0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    test_reset();
    test_count();
    test_wrap();
    test_reset_priority();
    test_hold_at_max();
`ifdef ASYNC_COUNTER_SAT_EN
    test_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
